// File: rtl/pla_eval.sv
// Pipelined, runtime-programmable AND-OR array (sum-of-products evaluator).
// Reset configuration implements Y = (A&B) | (C&D) for the 4-input, 2-term, 1-output build.
module pla_eval #(
  parameter int N_IN   = 4,
  parameter int N_TERM = 2,
  parameter int N_OUT  = 1,
  localparam int AW    = $clog2(N_TERM + N_OUT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_IN-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_OUT-1:0]    out_data,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [2*N_IN-1:0]   cfg_data,
  output logic                cfg_err
);

  // Term t defaults to the AND of input pair (2t, 2t+1); bits past N_IN are dropped.
  function automatic logic [N_IN-1:0] dflt_mask(input int t);
    logic [N_IN-1:0] m;
    for (int i = 0; i < N_IN; i++) begin
      m[i] = (i == 2 * t) || (i == 2 * t + 1);
    end
    return m;
  endfunction

  logic [N_IN-1:0]   mask_q [N_TERM];
  logic [N_IN-1:0]   pol_q  [N_TERM];
  logic [N_TERM-1:0] sel_q  [N_OUT];

  logic              v1, v2;
  logic [N_TERM-1:0] term_q;
  logic [N_TERM-1:0] term_d;
  logic [N_OUT-1:0]  out_d;

  logic              adv2, load1, load2;
  logic [31:0]       addr_ext;
  logic              addr_ok, cfg_ok;

  // Handshake: stage 2 frees when empty or drained; stage 1 can refill behind it.
  assign adv2     = !v2 || out_ready;
  assign in_ready = !v1 || adv2;
  assign load1    = in_valid && in_ready;
  assign load2    = v1 && adv2;

  assign addr_ext = 32'(cfg_addr);
  assign addr_ok  = addr_ext < 32'(N_TERM + N_OUT);
  // Writes only land while nothing is in flight, so data never sees a half-updated array.
  assign cfg_ok   = cfg_we && addr_ok && !v1 && !v2 && !in_valid;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    term_d = '0;
    for (int t = 0; t < N_TERM; t++) begin
      // A disabled term (empty mask) must read 0, not the vacuous AND of nothing.
      term_d[t] = (|mask_q[t]) && (&(~mask_q[t] | ~(in_data ^ pol_q[t])));
    end
  end

  always_comb begin
    out_d = '0;
    for (int o = 0; o < N_OUT; o++) begin
      out_d[o] = |(sel_q[o] & term_q);
    end
  end

  // NOTE: the configuration arrays are reset on purpose: they hold functional defaults,
  // not scratch storage, so a reset must restore the hard-wired function.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_TERM; t++) begin
        mask_q[t] <= dflt_mask(t);
        pol_q[t]  <= '1;
      end
      for (int o = 0; o < N_OUT; o++) begin
        sel_q[o] <= '1;
      end
    end else if (cfg_ok) begin
      for (int t = 0; t < N_TERM; t++) begin
        if (addr_ext == 32'(t)) begin
          mask_q[t] <= cfg_data[N_IN-1:0];
          pol_q[t]  <= cfg_data[2*N_IN-1:N_IN];
        end
      end
      for (int o = 0; o < N_OUT; o++) begin
        if (addr_ext == 32'(N_TERM + o)) begin
          sel_q[o] <= cfg_data[N_TERM-1:0];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      term_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      v1        <= load1 || (v1 && !adv2);
      v2        <= load2 || (v2 && !out_ready);
      out_valid <= load2 || (v2 && !out_ready);
      if (load1) term_q <= term_d;
      if (load2) out_data <= out_d;
      cfg_err   <= cfg_we && !cfg_ok;
    end
  end

endmodule

// File: tb/tb_pla_eval.sv
// Scoreboard bench for pla_eval: default function, reprogramming, backpressure,
// config rejection, reset mid-stream, plus a 6-input/3-term/2-output build.
module tb_pla_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_data;
  logic [0:0] out_data;
  logic       cfg_we, cfg_err;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;

  logic       in_valid6, in_ready6, out_valid6, cfg_err6;
  logic [5:0] in_data6;
  logic [1:0] out_data6;
  logic [2:0] cfg_addr6;
  logic [11:0] cfg_data6;

  typedef struct {
    logic exp;
    int   cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;
  bit   check_lat = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  pla_eval #(.N_IN(4), .N_TERM(2), .N_OUT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  pla_eval #(.N_IN(6), .N_TERM(3), .N_OUT(2)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .out_valid(out_valid6), .out_ready(1'b1), .out_data(out_data6),
    .cfg_we(1'b0), .cfg_addr(cfg_addr6), .cfg_data(cfg_data6), .cfg_err(cfg_err6)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor: pops the oldest expectation on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.exp));
        if (check_lat) check("latency", 32'(ncyc - mon_e.cyc), 32'd2);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] d, input logic e);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      if (check_lat) check("throughput_stall", 32'(w), 32'd0);
      sb_q.push_back('{exp: e, cyc: ncyc});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input string tag, input logic [1:0] a, input logic [7:0] d,
                           input logic exp_err);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
    check(tag, 32'(cfg_err), 32'(exp_err));
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_clear"}, 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dflt_tab;
    logic [5:0]  v6 [3];
    logic [1:0]  e6 [3];
    dflt_tab = 16'hF888;
    v6[0] = 6'b110000; e6[0] = 2'b11;
    v6[1] = 6'b000011; e6[1] = 2'b11;
    v6[2] = 6'b010101; e6[2] = 2'b00;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid6 = 1'b0; in_data6 = '0; cfg_addr6 = '0; cfg_data6 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;

    // Default function, back-to-back sweep of all 16 vectors.
    check_lat = 1'b1;
    for (int i = 0; i < 16; i++) send(4'(i), dflt_tab[i]);
    wait_drain();
    check_lat = 1'b0;

    // Backpressure: two samples held, third blocked, first output stable.
    out_ready = 1'b0;
    send(4'b0011, 1'b1);
    send(4'b0100, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_hold", 32'(out_data), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'b1100, 1'b1);
    wait_drain();

    // Rejected write while stage 2 is occupied; configuration must be unchanged.
    out_ready = 1'b0;
    send(4'b0011, 1'b1);
    @(posedge clk);
    #1;
    cfg_write("err_busy", 2'd0, 8'h00, 1'b1);
    out_ready = 1'b1;
    wait_drain();
    send(4'b0011, 1'b1);
    wait_drain();

    // Out-of-range address, two back-to-back rejects.
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 8'hFF;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("err_addr_0", 32'(cfg_err), 32'd1);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
    check("err_addr_1", 32'(cfg_err), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("err_addr_clear", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
    send(4'b1100, 1'b1);
    wait_drain();

    // Reprogram: term0 = A & ~C, term1 disabled.
    cfg_write("wr_term0", 2'd0, 8'b0001_0101, 1'b0);
    cfg_write("wr_term1", 2'd1, 8'h00, 1'b0);
    send(4'b0001, 1'b1);
    send(4'b0101, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b1100, 1'b0);
    wait_drain();
    // Output select: upper cfg_data bits ignored; 0xFE selects only the disabled term.
    cfg_write("wr_sel_a", 2'd2, 8'hFE, 1'b0);
    send(4'b0001, 1'b0);
    wait_drain();
    cfg_write("wr_sel_b", 2'd2, 8'hFD, 1'b0);
    send(4'b0001, 1'b1);
    wait_drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(4'b0001, 1'b1);
    send(4'b0001, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_data", 32'(out_data), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(4'b1100, 1'b1);
    send(4'b0001, 1'b0);
    wait_drain();

    // Six-input build: every output is AB | CD | EF by default.
    for (int i = 0; i < 3; i++) begin
      in_valid6 = 1'b1;
      in_data6  = v6[i];
      @(posedge clk);
      #1 in_valid6 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("p6_out_valid", 32'(out_valid6), 32'd1);
      check("p6_out_data", 32'(out_data6), 32'(e6[i]));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pla_eval.md
# pla_eval

Parametrised, pipelined programmable AND-OR array (sum-of-products evaluator). Each input vector is evaluated against runtime-programmable product terms: per-term input mask and polarity, per-output term select. Results return through a 2-stage valid/ready pipeline. Reset configuration reproduces the fixed 4-input function Y = (A&B) | (C&D), so the block drops in wherever that function was hard-wired and can then be reprogrammed in place.

## Interface
- N_IN, 4, number of primary inputs; range 2..16.
- N_TERM, 2, number of product terms; must satisfy N_TERM <= 2*N_IN.
- N_OUT, 1, number of outputs; range 1..8.
- AW, derived, $clog2(N_TERM+N_OUT).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  N_IN  input vector; bit0=A, bit1=B, bit2=C, bit3=D for defaults.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  N_OUT  evaluated outputs.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  AW  0..N_TERM-1 selects a term; N_TERM..N_TERM+N_OUT-1 selects an output.
- cfg_data  in  2*N_IN  term write: [N_IN-1:0] mask, [2N_IN-1:N_IN] polarity (1 = true, 0 = complemented); output write: [N_TERM-1:0] term select.
- cfg_err  out  1  one-cycle pulse when a write is rejected.

## Operation
- Term t = AND over i with mask[t][i]=1 of (pol[t][i] ? in_data[i] : ~in_data[i]).
  - mask all-zero: term is disabled and evaluates to 0, not 1.
- Output o = OR of terms with sel[o][t]=1. An output with sel all-zero evaluates to 0.
- Reset configuration:
  - Term t: mask bits 2t and 2t+1 set (bits >= N_IN dropped); polarity all ones.
  - Every output selects all terms.
  - With N_IN=4, N_TERM=2, N_OUT=1 this gives Y = (A&B) | (C&D).
- Pipeline:
  - Stage 1 (valid v1) registers the N_TERM term values.
  - Stage 2 (valid v2) registers out_data.
  - out_valid = v2.
  - adv2 = !v2 | out_ready.
  - in_ready = !v1 | adv2 (combinational through out_ready).
  - Stage 1 loads on in_valid & in_ready. Stage 2 loads from stage 1 on v1 & adv2.
  - v1 and v2 set and clear accordingly; simultaneous load and drain at each stage is allowed.
- Config writes:
  - Accepted only when v1=0, v2=0 and in_valid=0 in that cycle. Takes effect from the next edge.
  - Otherwise, or when cfg_addr >= N_TERM+N_OUT: write dropped, cfg_err=1 next cycle.
  - Term writes use cfg_data bits as defined above. Output writes ignore cfg_data bits >= N_TERM.
- Priority: when a write is accepted, the pipeline is idle, so there is no conflict with data.

## Timing
- Reset values: v1=v2=0, out_valid=0, out_data=0, stage-1 term regs=0, cfg_err=0, configuration at defaults. in_ready=1 from the first cycle after reset.
- Latency: a sample accepted at edge k gives out_valid=1 after edge k+1 when unstalled.
- Throughput: 1 sample/cycle with out_ready held high.
- Stall: with out_ready=0, out_data and out_valid are held stable. At most 2 samples are held. in_ready falls once both stages are full.
- Reset during traffic: in-flight samples are discarded and configuration returns to defaults. No output is produced for them.
- cfg_err is a single-cycle pulse per rejected write. Back-to-back rejects produce back-to-back pulses.

## Test plan
- Defaults: after reset, drive in_data 0000..1111 back-to-back with out_ready=1.
  - out_data=1 exactly for 0011, 0111, 1011, 1100, 1101, 1110, 1111.
  - Each result appears 2 cycles after its input.
  - One result per cycle.
- Reprogram:
  - Write term0 (mask=0101, pol=0001), i.e. A&~C. Write term1 mask=0, i.e. disabled.
  - in_data=0001 -> 1. in_data=0101 -> 0. in_data=1111 -> 0.
- Backpressure:
  - Hold out_ready=0 and push 3 samples. in_ready drops after 2 accepted, and the first output is held stable.
  - Release out_ready. Outputs emerge in order with none lost or duplicated.
- Config rejection: cfg_we while v2=1 -> cfg_err pulse, config unchanged. cfg_addr=3 with N_TERM=2, N_OUT=1 -> cfg_err pulse.
- Reset mid-stream: assert rst with both stages full.
  - Next cycle: out_valid=0, out_data=0, in_ready=1.
  - Defaults restored: in_data=1100 -> 1.
- Parametrised build N_IN=6, N_TERM=3, N_OUT=2: defaults give out0=out1=(AB|CD|EF). in_data=110000 -> 11.
